// File: rtl/ca_value_reader.sv
// rtl/ca_value_reader.sv - snapshot a 64-bit cell-state word and stream it out as nibbles
//
// Captures value_in on load (in IDLE only), then presents sixteen NIB_W-bit
// nibbles LSB-first over a valid/ready handshake. The LEDs mirror the SLICE_W
// slice that holds the nibble currently on offer. A one-cycle done pulse follows
// the last accepted nibble.
//
// Optional build macro: STEP_MODE_EN
//   defined   - a nibble is accepted only on out_ready AND a debounced-free
//               rising edge of the (synchronised) step button.
//   undefined - a nibble is accepted whenever out_ready is high; step is unused.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   load       in   capture value_in and start a stream (honoured in IDLE only)
//   value_in   in   WORD_W state word to read out
//   out_ready  in   consumer accepts the current nibble
//   step       in   manual step button (STEP_MODE_EN builds only)
//   out_valid  out  out_nibble/out_index are valid
//   out_nibble out  current nibble of the snapshot
//   out_index  out  nibble number 0..15
//   slice_sel  out  slice holding the current nibble (out_index[3:2])
//   led        out  snapshot slice selected by slice_sel
//   busy       out  high while streaming and during the done cycle
//   done       out  one-cycle pulse after the last nibble is accepted

module ca_value_reader #(
  parameter int WORD_W  = 64,
  parameter int SLICE_W = 16,
  parameter int NIB_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [WORD_W-1:0]  value_in,
  input  logic               out_ready,
  input  logic               step,
  output logic               out_valid,
  output logic [NIB_W-1:0]   out_nibble,
  output logic [3:0]         out_index,
  output logic [1:0]         slice_sel,
  output logic [SLICE_W-1:0] led,
  output logic               busy,
  output logic               done
);

  localparam logic [3:0] LAST_IDX = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t            state;
  logic [WORD_W-1:0] snap;
  logic              acc;
  logic              xfer;
  logic [3:0]        next_idx;

  function automatic logic [NIB_W-1:0] nib_at(input logic [WORD_W-1:0] w,
                                              input logic [3:0]        idx);
    logic [WORD_W-1:0] sh;
    sh = w >> (int'(idx) * NIB_W);
    return sh[NIB_W-1:0];
  endfunction

  function automatic logic [SLICE_W-1:0] slice_at(input logic [WORD_W-1:0] w,
                                                  input logic [1:0]        sel);
    logic [WORD_W-1:0] sh;
    sh = w >> (int'(sel) * SLICE_W);
    return sh[SLICE_W-1:0];
  endfunction

`ifdef STEP_MODE_EN
  logic step_s1;
  logic step_s2;
  logic step_prev;
  logic step_rise;

  // Two-flop synchroniser then edge detect: a held button yields one advance,
  // and a press while out_ready is low is simply lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_s1   <= 1'b0;
      step_s2   <= 1'b0;
      step_prev <= 1'b0;
    end else begin
      step_s1   <= step;
      step_s2   <= step_s1;
      step_prev <= step_s2;
    end
  end

  assign step_rise = step_s2 & ~step_prev;
  assign acc       = out_ready & step_rise;
`else
  logic unused_step;
  assign unused_step = step;
  assign acc         = out_ready;
`endif

  assign xfer     = out_valid & acc;
  assign next_idx = out_index + 4'd1;

  // out_nibble/led/slice_sel are loaded from the same next-index value as
  // out_index, so they move in the same cycle as the index does.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      snap       <= '0;
      out_index  <= '0;
      out_valid  <= 1'b0;
      out_nibble <= '0;
      slice_sel  <= '0;
      led        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load) begin
            snap       <= value_in;
            out_index  <= '0;
            slice_sel  <= '0;
            out_nibble <= nib_at(value_in, 4'd0);
            led        <= slice_at(value_in, 2'd0);
            out_valid  <= 1'b1;
            busy       <= 1'b1;
            state      <= S_STREAM;
          end
        end

        S_STREAM: begin
          if (xfer) begin
            if (out_index == LAST_IDX) begin
              // Index parks at 15 through the done cycle.
              out_valid <= 1'b0;
              done      <= 1'b1;
              state     <= S_DONE;
            end else begin
              out_index  <= next_idx;
              slice_sel  <= next_idx[3:2];
              out_nibble <= nib_at(snap, next_idx);
              led        <= slice_at(snap, next_idx[3:2]);
            end
          end
        end

        S_DONE: begin
          out_index  <= '0;
          slice_sel  <= '0;
          out_nibble <= nib_at(snap, 4'd0);
          led        <= slice_at(snap, 2'd0);
          busy       <= 1'b0;
          state      <= S_IDLE;
        end

        default: begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ca_value_reader.sv
// tb/tb_ca_value_reader.sv - self-checking bench for ca_value_reader
module tb_ca_value_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [63:0] value_in;
  logic        out_ready;
  logic        step;
  logic        out_valid;
  logic [3:0]  out_nibble;
  logic [3:0]  out_index;
  logic [1:0]  slice_sel;
  logic [15:0] led;
  logic        busy;
  logic        done;

  int pass_cnt  = 0;
  int total_cnt = 0;

  ca_value_reader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .value_in   (value_in),
    .out_ready  (out_ready),
    .step       (step),
    .out_valid  (out_valid),
    .out_nibble (out_nibble),
    .out_index  (out_index),
    .slice_sel  (slice_sel),
    .led        (led),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference: nibble i of a word is bits [4i+3:4i]; it lives in slice i/4.
  function automatic logic [63:0] model_nib(input logic [63:0] w, input int i);
    return (w >> (4 * i)) & 64'hF;
  endfunction

  function automatic logic [63:0] model_led(input logic [63:0] w, input int i);
    return (w >> (16 * (i / 4))) & 64'hFFFF;
  endfunction

  typedef struct {
    logic [63:0] word;
    logic [7:0]  ready_pat;
    bit          mid_load;
    logic [15:0] exp_led_first;
    logic [15:0] exp_led_last;
  } vec_t;

  // Drive one stream; ready follows ready_pat (bit cyc%8). Every presented
  // nibble is compared to the model; the done/idle tail is checked too.
  task automatic run_stream(input logic [63:0] word, input logic [7:0] pat,
                            input bit mid_load,
                            output logic [15:0] led_first, output logic [15:0] led_last);
    int exp_idx = 0;
    int xfers   = 0;
    int cyc     = 0;
    bit finished = 0;
    led_first = '0;
    led_last  = '0;
    @(negedge clk);
    load = 1'b1; value_in = word; out_ready = 1'b0;
    @(negedge clk);
    load = 1'b0; value_in = {$urandom, $urandom};
    check("first_valid", 64'(out_valid), 64'd1);
    while (!finished && cyc < 300) begin
      load = 1'b0;
      if (out_valid) begin
        check("index",     64'(out_index),  64'(exp_idx));
        check("nibble",    64'(out_nibble), model_nib(word, exp_idx));
        check("led",       64'(led),        model_led(word, exp_idx));
        check("slice_sel", 64'(slice_sel),  64'(exp_idx / 4));
        check("busy_strm", 64'(busy),       64'd1);
        check("done_strm", 64'(done),       64'd0);
        if (exp_idx == 0)  led_first = led;
        if (exp_idx == 15) led_last  = led;
        out_ready = pat[cyc % 8];
        if (mid_load && exp_idx == 5) begin
          load = 1'b1; value_in = 64'h0;
        end else begin
          value_in = {$urandom, $urandom};
        end
        if (out_ready) begin exp_idx++; xfers++; end
      end else begin
        check("done_pulse", 64'(done),      64'd1);
        check("busy_done",  64'(busy),      64'd1);
        check("index_hold", 64'(out_index), 64'd15);
        check("xfer_count", 64'(xfers),     64'd16);
        if (pat == 8'hFF) check("throughput", 64'(cyc), 64'd16);
        out_ready = 1'b0;
        finished = 1;
      end
      cyc++;
      @(negedge clk);
    end
    if (!finished) check("stream_timeout", 64'd0, 64'd1);
    else begin
      check("idle_done",  64'(done),      64'd0);
      check("idle_busy",  64'(busy),      64'd0);
      check("idle_valid", 64'(out_valid), 64'd0);
      check("idle_index", 64'(out_index), 64'd0);
    end
  endtask

  vec_t        vecs[5];
  logic [15:0] lf, ll;

  initial begin
    rst_n = 1'b0; load = 1'b0; value_in = '0; out_ready = 1'b0; step = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_valid", 64'(out_valid), 64'd0);
      check("rst_led",   64'(led),       64'd0);
      check("rst_busy",  64'(busy),      64'd0);
      check("rst_done",  64'(done),      64'd0);
      check("rst_index", 64'(out_index), 64'd0);
    end

`ifdef STEP_MODE_EN
    @(negedge clk);
    load = 1'b1; value_in = 64'hFEDC_BA98_7654_3210; out_ready = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (4) @(negedge clk);
    check("step_idle_hold", 64'(out_index), 64'd0);
    step = 1'b1;
    repeat (10) @(negedge clk);
    step = 1'b0;
    repeat (4) @(negedge clk);
    check("step_held_once", 64'(out_index), 64'd1);
    for (int p = 0; p < 3; p++) begin
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      repeat (4) @(negedge clk);
    end
    check("step_total",  64'(out_index),  64'd4);
    check("step_valid",  64'(out_valid),  64'd1);
    check("step_nibble", 64'(out_nibble), 64'd4);
`else
    vecs[0] = '{64'hFEDC_BA98_7654_3210, 8'hFF, 1'b0, 16'h3210, 16'hFEDC};
    vecs[1] = '{64'hFEDC_BA98_7654_3210, 8'h99, 1'b0, 16'h3210, 16'hFEDC};
    vecs[2] = '{64'hFEDC_BA98_7654_3210, 8'hFF, 1'b1, 16'h3210, 16'hFEDC};
    vecs[3] = '{64'h0123_4567_89AB_CDEF, 8'h55, 1'b0, 16'hCDEF, 16'h0123};
    vecs[4] = '{64'hFFFF_0000_FFFF_0000, 8'h01, 1'b1, 16'h0000, 16'hFFFF};
    for (int v = 0; v < 5; v++) begin
      run_stream(vecs[v].word, vecs[v].ready_pat, vecs[v].mid_load, lf, ll);
      check("vec_led_first", 64'(lf), 64'(vecs[v].exp_led_first));
      check("vec_led_last",  64'(ll), 64'(vecs[v].exp_led_last));
    end

    // Reset in the middle of a stream.
    @(negedge clk);
    load = 1'b1; value_in = 64'hFEDC_BA98_7654_3210; out_ready = 1'b1;
    @(negedge clk);
    load = 1'b0;
    for (int c = 0; c < 40 && out_index != 4'd7; c++) @(negedge clk);
    check("reach_idx7", 64'(out_index), 64'd7);
    rst_n = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    check("abort_valid", 64'(out_valid), 64'd0);
    check("abort_index", 64'(out_index), 64'd0);
    check("abort_busy",  64'(busy),      64'd0);
    check("abort_led",   64'(led),       64'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("abort_no_done", 64'(done), 64'd0);
    end
    run_stream(64'hA5A5_5A5A_1234_ABCD, 8'hFF, 1'b0, lf, ll);

    // load held high: one idle cycle between back-to-back streams.
    @(negedge clk);
    load = 1'b1; value_in = 64'h1111_2222_3333_4444; out_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 16; k++) begin
      check("b2b_valid", 64'(out_valid), 64'd1);
      check("b2b_index", 64'(out_index), 64'(k));
      @(negedge clk);
    end
    check("b2b_done",       64'(done),      64'd1);
    check("b2b_done_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    check("b2b_gap_valid",  64'(out_valid), 64'd0);
    check("b2b_gap_busy",   64'(busy),      64'd0);
    @(negedge clk);
    check("b2b_restart",    64'(out_valid), 64'd1);
    check("b2b_restart_ix", 64'(out_index), 64'd0);
    load = 1'b0;
    for (int c = 0; c < 40 && (out_valid || busy); c++) @(negedge clk);
    check("b2b_drained", 64'(busy), 64'd0);

    // Randomised streams against the reference model.
    for (int r = 0; r < 8; r++) begin
      logic [63:0] w;
      w = {$urandom, $urandom};
      run_stream(w, 8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)), lf, ll);
      check("rnd_led_first", 64'(lf), w & 64'hFFFF);
      check("rnd_led_last",  64'(ll), w >> 48);
    end
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
